// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
// Sequences an external up-counter through repeated index sweeps 0..limit
// for a programmable number of passes, using only the counter's rst/inc
// controls. Wrap-around at the end of each pass is always forced through
// cnt_rst, so the counter never has to overflow naturally.
//
// Optional feature: define SWEEP_ABORT_EN to add the abort input and the
// aborted pulse output.
module counter_sweep_ctrl #(
   parameter int CNT_W  = 7,
   parameter int PASS_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  limit,
   input  logic [PASS_W-1:0] passes,
   input  logic              stall,
   input  logic [CNT_W-1:0]  count_in,
   output logic              cnt_rst,
   output logic              cnt_inc,
   output logic              idx_valid,
   output logic              idx_last,
   output logic [PASS_W-1:0] pass_idx,
   output logic              busy,
   output logic              done
`ifdef SWEEP_ABORT_EN
   ,
   input  logic              abort,
   output logic              aborted
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [PASS_W-1:0] PASS_ONE = {{(PASS_W-1){1'b0}}, 1'b1};

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  limit_q;
   logic [PASS_W-1:0] passes_q;
   logic [PASS_W-1:0] pass_q;
   logic              load;
   logic              pass_adv;
   logic              abort_hit;
`ifdef SWEEP_ABORT_EN
   logic              aborted_q;
`endif

   // Next-state decode and all combinational controls; rst blanks every output
   always_comb begin
      state_d   = state_q;
      cnt_rst   = 1'b0;
      cnt_inc   = 1'b0;
      idx_valid = 1'b0;
      idx_last  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      pass_idx  = pass_q;
      load      = 1'b0;
      pass_adv  = 1'b0;
      abort_hit = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            busy    = 1'b1;
            cnt_rst = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (!stall) begin
               idx_valid = 1'b1;
               if (count_in == limit_q) begin
                  idx_last = 1'b1;
                  cnt_rst  = 1'b1;
                  if (pass_q == passes_q - PASS_ONE) begin
                     state_d = DONE;
                  end else begin
                     pass_adv = 1'b1;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef SWEEP_ABORT_EN
      abort_hit = abort && ((state_q == CLEAR) || (state_q == RUN));
`else
      abort_hit = 1'b0;
`endif

      if (abort_hit) begin
         cnt_rst   = 1'b1;
         cnt_inc   = 1'b0;
         idx_valid = 1'b0;
         idx_last  = 1'b0;
         pass_adv  = 1'b0;
         state_d   = IDLE;
      end

      if (rst) begin
         cnt_rst   = 1'b0;
         cnt_inc   = 1'b0;
         idx_valid = 1'b0;
         idx_last  = 1'b0;
         busy      = 1'b0;
         done      = 1'b0;
         pass_idx  = '0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Sweep parameters are captured on an accepted start; a zero pass count runs once
   always_ff @(posedge clk) begin
      if (rst) begin
         limit_q  <= '0;
         passes_q <= '0;
         pass_q   <= '0;
      end else if (load) begin
         limit_q  <= limit;
         passes_q <= (passes == '0) ? PASS_ONE : passes;
         pass_q   <= '0;
      end else if (pass_adv) begin
         pass_q   <= pass_q + PASS_ONE;
      end
   end

`ifdef SWEEP_ABORT_EN
   // Aborted pulse appears the cycle after the abort was taken
   always_ff @(posedge clk) begin
      if (rst) begin
         aborted_q <= 1'b0;
      end else begin
         aborted_q <= abort_hit;
      end
   end

   assign aborted = aborted_q & ~rst;
`endif

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb_counter_sweep_ctrl
// Directed bench for counter_sweep_ctrl driving a behavioural 7-bit counter.
// Define SWEEP_ABORT_EN to also exercise the abort path.
module tb_counter_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [6:0] limit = '0;
   logic [3:0] passes = '0;
   logic       stall = 1'b0;
   logic [6:0] count_in;
   logic       cnt_rst;
   logic       cnt_inc;
   logic       idx_valid;
   logic       idx_last;
   logic [3:0] pass_idx;
   logic       busy;
   logic       done;
`ifdef SWEEP_ABORT_EN
   logic       abort = 1'b0;
   logic       aborted;
`endif

   int compared = 0;
   int mismatched = 0;

   // Expected per-cycle controls for limit=3, passes=2:
   // {cnt_rst, cnt_inc, idx_valid, idx_last, busy, done}
   logic [5:0] basic_ctl [0:11] = '{
      6'b000000, 6'b100010, 6'b011010, 6'b011010, 6'b011010, 6'b101110,
      6'b011010, 6'b011010, 6'b011010, 6'b101110, 6'b000001, 6'b000000};
   int basic_cnt  [0:11] = '{0, 0, 0, 1, 2, 3, 0, 1, 2, 3, 0, 0};
   int basic_pass [0:11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

   counter_sweep_ctrl #(.CNT_W(7), .PASS_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .limit     (limit),
      .passes    (passes),
      .stall     (stall),
      .count_in  (count_in),
      .cnt_rst   (cnt_rst),
      .cnt_inc   (cnt_inc),
      .idx_valid (idx_valid),
      .idx_last  (idx_last),
      .pass_idx  (pass_idx),
      .busy      (busy),
      .done      (done)
`ifdef SWEEP_ABORT_EN
      ,
      .abort     (abort),
      .aborted   (aborted)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   // External counter sharing the controller's reset
   always_ff @(posedge clk) begin
      if (rst || cnt_rst) begin
         count_in <= '0;
      end else if (cnt_inc) begin
         count_in <= count_in + 7'd1;
      end
   end

   // Safety net so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation exceeded time budget");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic checkCycle(input string tag, input logic [5:0] ectl, input int ecnt, input int epass);
      checkOutput({tag, ".ctl"}, int'({cnt_rst, cnt_inc, idx_valid, idx_last, busy, done}), int'(ectl));
      checkOutput({tag, ".cnt"}, int'(count_in), ecnt);
      checkOutput({tag, ".pass"}, int'(pass_idx), epass);
   endtask

   task automatic applyStimulus(input logic s, input logic [6:0] lim, input logic [3:0] pas, input logic stl);
      start  = s;
      limit  = lim;
      passes = pas;
      stall  = stl;
      #2;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 7'd0, 4'd0, 1'b0);
      nextCycle();
      nextCycle();
      rst = 1'b0;
   endtask

   // mode 0: plain sweep; mode 1: extra start pulses mid-sweep and on DONE
   task automatic runBasic(input string tag, input int mode, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         if (c == 0) begin
            applyStimulus(1'b1, 7'd3, 4'd2, 1'b0);
         end else if (mode == 1) begin
            applyStimulus((c == 4) || (c == 10), 7'd9, 4'd5, 1'b0);
         end else begin
            applyStimulus(1'b0, 7'd3, 4'd2, 1'b0);
         end
         checkCycle($sformatf("%s c%0d", tag, c), basic_ctl[c], basic_cnt[c], basic_pass[c]);
         nextCycle();
      end
   endtask

   initial begin
      $display("[TB] counter_sweep_ctrl directed test");

      // Reset state, both during and just after rst
      rst = 1'b1;
      applyStimulus(1'b0, 7'd0, 4'd0, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 7'd5, 4'd1, 1'b0);
      checkCycle("reset hold", 6'b000000, 0, 0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 7'd5, 4'd1, 1'b0);
      checkCycle("reset after", 6'b000000, 0, 0);
      nextCycle();

      // Basic sweep limit=3 passes=2
      doReset();
      runBasic("basic", 0, 12);

      // Stall holds index 1 for three cycles
      doReset();
      for (int c = 0; c < 10; c++) begin
         applyStimulus(c == 0, 7'd2, 4'd1, (c >= 3) && (c <= 5));
         case (c)
            0:       checkCycle($sformatf("stall c%0d", c), 6'b000000, 0, 0);
            1:       checkCycle($sformatf("stall c%0d", c), 6'b100010, 0, 0);
            2:       checkCycle($sformatf("stall c%0d", c), 6'b011010, 0, 0);
            3, 4, 5: checkCycle($sformatf("stall c%0d", c), 6'b000010, 1, 0);
            6:       checkCycle($sformatf("stall c%0d", c), 6'b011010, 1, 0);
            7:       checkCycle($sformatf("stall c%0d", c), 6'b101110, 2, 0);
            8:       checkCycle($sformatf("stall c%0d", c), 6'b000001, 0, 0);
            default: checkCycle($sformatf("stall c%0d", c), 6'b000000, 0, 0);
         endcase
         nextCycle();
      end

      // limit=0, passes=0 behaves as a single one-index pass
      doReset();
      applyStimulus(1'b1, 7'd0, 4'd0, 1'b0);
      checkCycle("lim0 c0", 6'b000000, 0, 0);
      nextCycle();
      applyStimulus(1'b0, 7'd0, 4'd0, 1'b0);
      checkCycle("lim0 c1", 6'b100010, 0, 0);
      nextCycle();
      applyStimulus(1'b0, 7'd0, 4'd0, 1'b0);
      checkCycle("lim0 c2", 6'b101110, 0, 0);
      nextCycle();
      applyStimulus(1'b0, 7'd0, 4'd0, 1'b0);
      checkCycle("lim0 c3", 6'b000001, 0, 0);
      nextCycle();
      applyStimulus(1'b0, 7'd0, 4'd0, 1'b0);
      checkCycle("lim0 c4", 6'b000000, 0, 0);
      nextCycle();

      // Full-range sweep 0..127
      doReset();
      applyStimulus(1'b1, 7'd127, 4'd1, 1'b0);
      checkCycle("full start", 6'b000000, 0, 0);
      nextCycle();
      applyStimulus(1'b0, 7'd127, 4'd1, 1'b0);
      checkCycle("full clear", 6'b100010, 0, 0);
      nextCycle();
      for (int i = 0; i < 128; i++) begin
         applyStimulus(1'b0, 7'd127, 4'd1, 1'b0);
         checkCycle($sformatf("full i%0d", i), (i == 127) ? 6'b101110 : 6'b011010, i, 0);
         nextCycle();
      end
      applyStimulus(1'b0, 7'd127, 4'd1, 1'b0);
      checkCycle("full done", 6'b000001, 0, 0);
      nextCycle();

      // Start pulses while busy and on DONE are ignored
      doReset();
      runBasic("busystart", 1, 12);

      // Reset during pass 1, then a clean sweep
      doReset();
      runBasic("premid", 0, 7);
      rst = 1'b1;
      applyStimulus(1'b0, 7'd3, 4'd2, 1'b0);
      checkCycle("rstmid hold", 6'b000000, 1, 0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 7'd3, 4'd2, 1'b0);
      checkCycle("rstmid after", 6'b000000, 0, 0);
      nextCycle();
      runBasic("postrst", 0, 12);

`ifdef SWEEP_ABORT_EN
      // Abort at index 2 of pass 0
      doReset();
      for (int c = 0; c < 7; c++) begin
         abort = (c == 4);
         applyStimulus(c == 0, 7'd3, 4'd2, 1'b0);
         case (c)
            0:       checkCycle("abort c0", 6'b000000, 0, 0);
            1:       checkCycle("abort c1", 6'b100010, 0, 0);
            2:       checkCycle("abort c2", 6'b011010, 0, 0);
            3:       checkCycle("abort c3", 6'b011010, 1, 0);
            4:       checkCycle("abort c4", 6'b100010, 2, 0);
            default: checkCycle($sformatf("abort c%0d", c), 6'b000000, 0, 0);
         endcase
         checkOutput($sformatf("abort c%0d.aborted", c), int'(aborted), (c == 5) ? 1 : 0);
         nextCycle();
      end
      abort = 1'b0;

      // Abort coinciding with the final idx_last
      doReset();
      for (int c = 0; c < 6; c++) begin
         abort = (c == 3);
         applyStimulus(c == 0, 7'd1, 4'd1, 1'b0);
         case (c)
            0:       checkCycle("abortlast c0", 6'b000000, 0, 0);
            1:       checkCycle("abortlast c1", 6'b100010, 0, 0);
            2:       checkCycle("abortlast c2", 6'b011010, 0, 0);
            3:       checkCycle("abortlast c3", 6'b100010, 1, 0);
            default: checkCycle($sformatf("abortlast c%0d", c), 6'b000000, 0, 0);
         endcase
         checkOutput($sformatf("abortlast c%0d.aborted", c), int'(aborted), (c == 4) ? 1 : 0);
         nextCycle();
      end
      abort = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer that drives an external 7-bit up-counter through its `rst`/`inc` controls. It produces repeated index sweeps 0..limit for a programmable number of passes. A start/busy/done handshake connects it to the upstream control FSM, and a stall input lets the downstream consumer (e.g. memory read port) back-pressure the sweep. Each cycle it flags the index currently on the counter output as valid, last-of-pass or final.

Parameters:
CNT_W, 7, width of counter value and limit.
PASS_W, 4, width of pass count and pass index.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset; the driven counter shares this reset
start  input  1  request a sweep; sampled only in IDLE
limit  input  CNT_W  inclusive last index of each pass; latched on accepted start
passes  input  PASS_W  number of passes; latched on accepted start; 0 treated as 1
stall  input  1  consumer not ready; freezes the sweep this cycle
count_in  input  CNT_W  current value of the driven counter
cnt_rst  output  1  to counter `rst`
cnt_inc  output  1  to counter `inc`
idx_valid  output  1  count_in is a valid index this cycle and is consumed
idx_last  output  1  idx_valid and count_in == limit_q
pass_idx  output  PASS_W  current pass number, 0-based
busy  output  1  high in CLEAR and RUN
done  output  1  one-cycle pulse on sweep completion

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- States: IDLE, CLEAR, RUN, DONE. The state register and limit_q, passes_q and pass_idx are registered. cnt_rst, cnt_inc, idx_valid, idx_last and busy are combinational from state and inputs. done = (state==DONE).
- Reset: state=IDLE, pass_idx=0, limit_q=0, passes_q=0. Every output is 0 while rst is high and in the cycle after.
- IDLE:
  - start=1 latches limit_q=limit and passes_q=max(passes,1), clears pass_idx, and moves to CLEAR.
  - start=0 stays in IDLE.
- CLEAR: cnt_rst=1 for exactly one cycle, then RUN. The first index (0) is valid 2 cycles after start.
- RUN, stall=1: idx_valid=0, cnt_inc=0, cnt_rst=0; state and pass_idx hold. Stall may last any number of cycles.
- RUN, stall=0, count_in != limit_q: idx_valid=1, cnt_inc=1.
- RUN, stall=0, count_in == limit_q: idx_valid=1, idx_last=1, cnt_inc=0, cnt_rst=1. The counter wraps to 0 with no bubble cycle.
  - If pass_idx == passes_q-1: go to DONE.
  - Otherwise: pass_idx increments and the controller stays in RUN.
- DONE: done=1 and busy=0 for one cycle, then IDLE. start is ignored in DONE; it is accepted from the following IDLE cycle.
- Timing: with no stall, a sweep takes 2 + passes_q*(limit_q+1) + 1 cycles from start to done inclusive.
- start while busy: ignored; the latched limit and passes are unchanged.
- limit=0: one valid index per pass; cnt_rst is asserted every RUN cycle.
- limit=2^CNT_W-1: the full 0..127 range is swept. The controller never relies on natural counter overflow; wrap is always via cnt_rst.
- cnt_rst and cnt_inc are never both 1.
- Reset mid-sweep: the controller returns to IDLE immediately with no done pulse. The counter is cleared by the shared rst.
- The controller trusts count_in. Behaviour is undefined if the counter is driven by another master during busy.

Optional Feature:
- Macro SWEEP_ABORT_EN.
- When defined:
  - Adds input `abort` (1 bit) and output `aborted` (1-bit pulse).
  - abort=1 in CLEAR or RUN, regardless of stall: the controller asserts cnt_rst=1 that cycle, suppresses idx_valid, goes to IDLE and pulses aborted=1 the next cycle; done is not asserted.
  - abort=1 in the same cycle as the final idx_last: abort wins.
  - abort is ignored in IDLE and DONE.
- When not defined: neither port exists and there is no abort path.

Test Plan:
- Basic sweep: reset, start at cycle 0 with limit=3, passes=2, stall=0.
  - cnt_rst=1 at cycle 1.
  - idx_valid at cycles 2-9 with count_in 0,1,2,3,0,1,2,3; idx_last at cycles 5 and 9; pass_idx 0 then 1.
  - done at cycle 10; busy=0 at cycle 11.
- Stall: limit=2, passes=1, stall high during cycles 3-5.
  - Index 1 is presented at cycle 3 and held with no inc until stall drops; it is consumed at cycle 6.
  - Index 2 at cycle 7, done at cycle 8.
- Boundaries:
  - limit=0, passes=0: exactly 1 idx_valid with idx_last, then done.
  - limit=127, passes=1: 128 valid indices 0..127, then done; count_in never observed overflowing.
- start during busy: pulse start with new limit=9 mid-sweep.
  - Ignored; the original sweep completes unchanged.
  - A new start on the DONE cycle is also ignored.
- Reset mid-sweep: rst high during pass 1.
  - Next cycle: IDLE, all outputs 0, no done.
  - A subsequent start runs a full, correct sweep.
- Abort (SWEEP_ABORT_EN): abort at index 2 of pass 0.
  - cnt_rst=1 and idx_valid=0 that cycle; aborted=1 next cycle; done never asserted.
  - Repeat with abort coinciding with the final idx_last: aborted fires, done does not.
